inputbuf_pack: RTL and testbench
================================

Name: inputbuf_pack

Overview:
- Input-buffer front stage. Collects a serial sample stream into groups of 3 (mode=1) or 4 (mode=0) samples.
- Each complete group is emitted as one 4-lane word with valid/ready handshake into a 2-entry output queue.
- Directly feeds the mode-selectable modulo-3/4 lane counter stage: both blocks share the same mode encoding and lane-index range (0..I-1).

Parameters:
- DW, 16, sample width in bits.
- LANES, 4, maximum lanes per output word; fixed at 4, exposed for package consistency only.

Ports:
- clk  in  1  rising-edge clock.
- r  in  1  asynchronous active-high reset.
- mode  in  1  group size select: 1 gives I=3, 0 gives I=4.
- in_data  in  DW  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- out_data  out  4*DW  packed word; lane k occupies bits [(k+1)*DW-1 : k*DW].
- out_cnt  out  3  number of valid lanes in out_data (1..4).
- out_valid  out  1  out_data/out_cnt valid.
- out_ready  in  1  word consumed when out_valid && out_ready.
- busy  out  1  high while a group is partially filled or the queue is non-empty.
- flush  in  1  only when INPUTBUF_PACK_FLUSH_EN is defined.

Behaviour:
- Reset, asynchronous on r: lane=0, mode_q=0, stage=0, queue count=0, out_valid=0, out_data=0, out_cnt=0, busy=0. Reset mid-group discards the partial group and all queued words.
- FSM has two states:
  - IDLE (lane==0): on an accepted sample, latch mode_q<=mode, write stage lane 0, lane<=1, go to FILL.
  - FILL: each accepted sample writes stage[lane].
    - If lane==I-1, where I is derived from mode_q: push {stage with the new sample, cnt=I} to the queue, clear stage, lane<=0, go to IDLE.
    - Otherwise lane<=lane+1.
- Mode is sampled only at group start. mode changes during FILL have no effect until the next group.
- In mode 1, lane 3 of the pushed word is 0 and out_cnt=3.
- Single-sample group: when I is never 1, the IDLE-to-FILL transition always applies.
- in_ready = (count<2) || (lane != I-1). It never depends on out_ready, so there is no combinational path from out_ready to in_ready.
- Queue is a 2-entry FIFO with registered head. out_valid = (count!=0).
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push into an empty queue: word visible on out_data the next cycle. Latency is 1 clk from the final accepted sample to out_valid.
  - Pop when count==1 with no push: out_valid goes low the next cycle; out_data holds its last value.
- Full queue (count==2) and lane==I-1: in_ready=0 and the sample stalls. Samples at lanes below I-1 are still accepted into stage.
- busy = (lane!=0) || (count!=0).
- Sustained throughput is 1 sample/clk when out_ready is held high.

Optional Feature:
- INPUTBUF_PACK_FLUSH_EN defined:
  - Adds the flush input.
  - A flush in FILL with room in the queue (count<2, or a pop in the same cycle) pushes the partial group with out_cnt=lane and unfilled lanes zero, then goes to IDLE.
  - If the queue is full, the flush is held pending until room exists. New samples are not accepted while a flush is pending.
  - Flush in IDLE is ignored.
  - Flush in the same cycle as the group-completing sample: the group completes normally and the flush is ignored.
- Undefined: no flush port; only full groups are ever emitted.

Decomposition:
- Package inputbuf_pkg:
  - INPUTBUF_LANES=4, INPUTBUF_I_MODE1=3, INPUTBUF_I_MODE0=4.
  - typedef lane_idx_t (2 bits).
  - typedef cnt_t (3 bits).
  - FSM state enum {IDLE, FILL}.
  - These constants are shared with the lane counter stage.
- Sub-module inputbuf_ofifo2: 2-entry FIFO of width 4*DW+3 with push/pop/count, asynchronous reset.

Test Plan:
- mode=0, samples 0x0001..0x0008 streamed with out_ready=1: two words, 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005, out_cnt=4, each out_valid 1 clk after its 4th sample.
- mode=1, samples 0xA,0xB,0xC: one word 0x0000_000C_000B_000A with out_cnt=3. Toggling mode to 0 after the first sample does not change this word.
- out_ready=0, mode=0, 12 samples offered: 8 accepted into the queue, 3 staged, in_ready low with lane==3. Raising out_ready for 1 clk resumes with the 12th sample accepted and order preserved.
- Assert r mid-group (lane=2, count=1): all outputs 0 immediately. The next 4 samples form a fresh word.
- With FLUSH_EN, mode=0, two samples 0x11 and 0x22 then flush: word 0x0000_0000_0022_0011, out_cnt=2, lane back to 0.
- With FLUSH_EN, flush in the same cycle as the 4th sample: single full word with out_cnt=4, no extra word.

Source files
------------

// File: rtl/inputbuf_pkg.sv
// Shared constants and types for the input-buffer packer and the lane counter stage.
// The optional flush feature is enabled by INPUTBUF_PACK_FLUSH_EN.
package inputbuf_pkg;

  localparam int INPUTBUF_LANES   = 4;
  localparam int INPUTBUF_I_MODE1 = 3;
  localparam int INPUTBUF_I_MODE0 = 4;

  typedef logic [1:0] lane_idx_t;
  typedef logic [2:0] cnt_t;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  function automatic cnt_t grp_size(input logic m);
    return m ? cnt_t'(INPUTBUF_I_MODE1)
             : cnt_t'(INPUTBUF_I_MODE0);
  endfunction

  function automatic lane_idx_t last_lane(input logic m);
    return m ? lane_idx_t'(INPUTBUF_I_MODE1 - 1)
             : lane_idx_t'(INPUTBUF_I_MODE0 - 1);
  endfunction

endpackage

// File: rtl/inputbuf_pack_if.sv
// Sample-in / word-out handshake bundle of the input-buffer packer.
// Flush (INPUTBUF_PACK_FLUSH_EN) stays a plain port on the top.
interface inputbuf_pack_if #(
  parameter int DW = 16
);
  import inputbuf_pkg::*;

  logic [DW-1:0]                  in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [INPUTBUF_LANES*DW-1:0]   out_data;
  cnt_t                           out_cnt;
  logic                           out_valid;
  logic                           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_cnt, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_cnt, out_valid
  );

endinterface

// File: rtl/inputbuf_ofifo2.sv
// Two-entry output FIFO with a registered head; the head holds after the last pop.
// Callers must not push when full nor pop when empty.
module inputbuf_ofifo2 #(
  parameter int W = 67
) (
  input  logic         clk,
  input  logic         r,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;

  assign dout = head;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head <= din;
          end
        end
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inputbuf_pack.sv
// Packs a serial sample stream into 3- or 4-lane words feeding a 2-entry queue.
// Define INPUTBUF_PACK_FLUSH_EN to add the partial-group flush input.
module inputbuf_pack
  import inputbuf_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = INPUTBUF_LANES
) (
  input  logic clk,
  input  logic r,
  input  logic mode,
  output logic busy,
`ifdef INPUTBUF_PACK_FLUSH_EN
  input  logic flush,
`endif
  inputbuf_pack_if.slave io
);

  localparam int W = LANES*DW + 3;

  state_t          state;
  lane_idx_t       lane;
  lane_idx_t       last;
  logic            mode_q;
  logic [DW-1:0]   stage [LANES];
  logic [1:0]      count;
  logic            full;
  logic            acc;
  logic            done;
  logic            pop;
  logic            push;
  logic            fl_push;
  logic            fl_hold;
  logic [LANES*DW-1:0] word;
  cnt_t            wcnt;
  logic [W-1:0]    head;

  assign last = last_lane(mode_q);
  assign full = count == 2'd2;
  assign pop  = io.out_valid && io.out_ready;

`ifdef INPUTBUF_PACK_FLUSH_EN
  logic pend;
  logic fl_req;
  assign fl_req  = (flush || pend) && state == FILL;
  // a pending or fresh partial flush blocks samples that would extend the group
  assign fl_hold = pend || (flush && state == FILL && lane != last);
  assign fl_push = fl_req && !done && (!full || pop);
`else
  assign fl_hold = 1'b0;
  assign fl_push = 1'b0;
`endif

  assign io.in_ready = (!full || lane != last) && !fl_hold;
  assign acc  = io.in_valid && io.in_ready;
  assign done = acc && lane == last;
  assign push = done || fl_push;

  always_comb begin
    word = '0;
    for (int k = 0; k < LANES; k++) begin
      word[k*DW +: DW] = (acc && lane == lane_idx_t'(k))
                       ? io.in_data : stage[k];
    end
    wcnt = done ? grp_size(mode_q) : {1'b0, lane};
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= IDLE;
      lane   <= '0;
      mode_q <= 1'b0;
      for (int k = 0; k < LANES; k++) stage[k] <= '0;
`ifdef INPUTBUF_PACK_FLUSH_EN
      pend   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            mode_q   <= mode;
            stage[0] <= io.in_data;
            lane     <= 2'd1;
            state    <= FILL;
          end
        end
        FILL: begin
          if (push) begin
            for (int k = 0; k < LANES; k++) stage[k] <= '0;
            lane  <= '0;
            state <= IDLE;
          end else if (acc) begin
            stage[lane] <= io.in_data;
            lane        <= lane + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef INPUTBUF_PACK_FLUSH_EN
      if (push)        pend <= 1'b0;
      else if (fl_req) pend <= 1'b1;
`endif
    end
  end

  inputbuf_ofifo2 #(.W(W)) u_fifo (
    .clk   (clk),
    .r     (r),
    .push  (push),
    .pop   (pop),
    .din   ({wcnt, word}),
    .dout  (head),
    .count (count)
  );

  assign io.out_valid = count != 2'd0;
  assign io.out_data  = head[LANES*DW-1:0];
  assign io.out_cnt   = head[W-1 -: 3];
  assign busy = (lane != 2'd0) || (count != 2'd0);

endmodule

// File: tb/tb_inputbuf_pack.sv
// Directed plus randomized bench for inputbuf_pack against a queue-based model.
// Flush scenarios run when INPUTBUF_PACK_FLUSH_EN is defined.
module tb_inputbuf_pack;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  c;
  } w_t;

  logic clk = 1'b0;
  logic r;
  logic mode;
  logic busy;
`ifdef INPUTBUF_PACK_FLUSH_EN
  logic flush;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] grp[$];
  bit          gmode;
  w_t          q[$];
  logic [63:0] last_d;
  logic [2:0]  last_c;
  bit          pend_m;
  bit          acc_m;
  logic [63:0] got_d[$];
  logic [2:0]  got_c[$];

  inputbuf_pack_if #(.DW(16)) io ();

  always #5 clk = ~clk;

  inputbuf_pack #(.DW(16), .LANES(4)) dut (
    .clk  (clk),
    .r    (r),
    .mode (mode),
    .busy (busy),
`ifdef INPUTBUF_PACK_FLUSH_EN
    .flush(flush),
`endif
    .io   (io)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int isz();
    if (grp.size() == 0) return 4;
    return gmode ? 3 : 4;
  endfunction

  function automatic bit exp_rdy(input bit fl);
    bit base;
    base = (q.size() < 2) || (grp.size() != isz() - 1);
    return base && !pend_m &&
           !(fl && grp.size() > 0 && grp.size() != isz() - 1);
  endfunction

  function automatic logic [63:0] pack_grp();
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < grp.size(); k++) w[k*16 +: 16] = grp[k];
    return w;
  endfunction

  task automatic model_reset();
    grp.delete();
    q.delete();
    gmode  = 1'b0;
    last_d = '0;
    last_c = '0;
    pend_m = 1'b0;
  endtask

  task automatic check_outs(input bit fl);
    chk("in_ready",  64'(io.in_ready),  64'(exp_rdy(fl)));
    chk("out_valid", 64'(io.out_valid), 64'(q.size() != 0));
    chk("out_data",  io.out_data, q.size() ? q[0].d : last_d);
    chk("out_cnt",   64'(io.out_cnt), 64'(q.size() ? q[0].c : last_c));
    chk("busy",      64'(busy), 64'(grp.size() != 0 || q.size() != 0));
  endtask

  task automatic model_edge(input bit v, input logic [15:0] d, input bit m,
                            input bit ordy, input bit fl);
    bit pop, was_fill, done, push_en;
    w_t w;
    pop      = q.size() > 0 && ordy;
    was_fill = grp.size() > 0;
    acc_m    = v && exp_rdy(fl);
    done     = 1'b0;
    push_en  = 1'b0;
    if (acc_m) begin
      if (grp.size() == 0) gmode = m;
      grp.push_back(d);
      if (grp.size() == isz()) begin
        w.d = pack_grp();
        w.c = 3'(grp.size());
        grp.delete();
        push_en = 1'b1;
        done    = 1'b1;
      end
    end
    if ((fl || pend_m) && was_fill && !done) begin
      if (q.size() < 2 || pop) begin
        w.d = pack_grp();
        w.c = 3'(grp.size());
        grp.delete();
        push_en = 1'b1;
        pend_m  = 1'b0;
      end else begin
        pend_m = 1'b1;
      end
    end else begin
      pend_m = 1'b0;
    end
    if (pop) begin
      last_d = q[0].d;
      last_c = q[0].c;
      void'(q.pop_front());
    end
    if (push_en) q.push_back(w);
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit m,
                      input bit ordy, input bit fl);
    io.in_valid  = v;
    io.in_data   = d;
    mode         = m;
    io.out_ready = ordy;
`ifdef INPUTBUF_PACK_FLUSH_EN
    flush = fl;
`endif
    @(negedge clk);
    check_outs(fl);
    if (io.out_valid && ordy) begin
      got_d.push_back(io.out_data);
      got_c.push_back(io.out_cnt);
    end
    model_edge(v, d, m, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [15:0] nxt;
    r            = 1'b1;
    mode         = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
`ifdef INPUTBUF_PACK_FLUSH_EN
    flush = 1'b0;
`endif
    model_reset();
    #12;
    check_outs(1'b0);
    @(posedge clk);
    #1;
    r = 1'b0;

    // mode 0 stream of eight samples
    got_d.delete(); got_c.delete();
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("t1_nwords", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      chk("t1_w0", got_d[0], 64'h0004_0003_0002_0001);
      chk("t1_w1", got_d[1], 64'h0008_0007_0006_0005);
      chk("t1_c0", 64'(got_c[0]), 64'd4);
    end

    // mode 1 group, mode toggled mid-group
    got_d.delete(); got_c.delete();
    step(1, 16'hA, 1, 1, 0);
    step(1, 16'hB, 0, 1, 0);
    step(1, 16'hC, 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("t2_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      chk("t2_w", got_d[0], 64'h0000_000C_000B_000A);
      chk("t2_c", 64'(got_c[0]), 64'd3);
    end

    // back-pressure: 12 samples offered into a blocked output
    got_d.delete(); got_c.delete();
    nxt = 16'd1;
    for (int i = 0; i < 14; i++) begin
      step(1, nxt, 0, 0, 0);
      if (acc_m) nxt++;
    end
    chk("t3_accepted", 64'(nxt), 64'd12);
    chk("t3_stall_rdy", 64'(io.in_ready), 64'd0);
    step(1, nxt, 0, 1, 0);
    step(1, nxt, 0, 0, 0);
    chk("t3_resume", 64'(acc_m), 64'd1);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("t3_nwords", 64'(got_d.size()), 64'd3);
    if (got_d.size() == 3) begin
      chk("t3_w0", got_d[0], 64'h0004_0003_0002_0001);
      chk("t3_w1", got_d[1], 64'h0008_0007_0006_0005);
      chk("t3_w2", got_d[2], 64'h000C_000B_000A_0009);
    end

    // asynchronous reset with lane=2 and one queued word
    for (int i = 1; i <= 6; i++) step(1, 16'(16'h40 + i), 0, 0, 0);
    #2;
    r = 1'b1;
    #1;
    model_reset();
    check_outs(1'b0);
    @(posedge clk);
    #1;
    r = 1'b0;
    got_d.delete(); got_c.delete();
    for (int i = 1; i <= 4; i++) step(1, 16'(16'h50 + i), 0, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("t4_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) chk("t4_w", got_d[0], 64'h0054_0053_0052_0051);

`ifdef INPUTBUF_PACK_FLUSH_EN
    // partial flush
    got_d.delete(); got_c.delete();
    step(1, 16'h11, 0, 1, 0);
    step(1, 16'h22, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("f1_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) begin
      chk("f1_w", got_d[0], 64'h0000_0000_0022_0011);
      chk("f1_c", 64'(got_c[0]), 64'd2);
    end
    // flush with group-completing sample
    got_d.delete(); got_c.delete();
    for (int i = 1; i <= 3; i++) step(1, 16'(16'h60 + i), 0, 1, 0);
    step(1, 16'h64, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    chk("f2_nwords", 64'(got_d.size()), 64'd1);
    if (got_d.size() == 1) chk("f2_c", 64'(got_c[0]), 64'd4);
`endif

    // randomized traffic
    n = 0;
    for (int i = 0; i < 600; i++) begin
      bit fl;
      fl = 1'b0;
`ifdef INPUTBUF_PACK_FLUSH_EN
      fl = ($urandom_range(0, 15) == 0);
`endif
      step($urandom_range(0, 3) != 0, 16'($urandom),
           ($urandom_range(0, 7) == 0) ? ~mode : mode,
           $urandom_range(0, 2) != 0, fl);
      if (acc_m) n++;
    end
    chk("rand_progress", 64'(n > 100), 64'd1);
    repeat (4) step(0, 0, mode, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
